// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core: control-word layout,
// ALU operation encodings and the bubble control word.
package mips_pipe_pkg;

    localparam int CTRL_W = 6;

    // Bit positions inside the {RegWr, ALUSrc, MemtoReg, MemWr, Branch, Jump} control word
    localparam int CTRL_JUMP     = 0;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_MEMWR    = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGWR    = 5;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluctr_e;

    // Which way the ID/EX register moves on the next edge
    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_STALL  = 2'd2,
        ACT_FLUSH  = 2'd3
    } idex_act_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the
// instruction in ID. Pure combinational so branch-in-ID logic can share it.
module load_use_detect #(
    parameter int RW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_memtoreg,
    input  logic [RW-1:0] ex_rw,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rt,
    output logic          lu_hit
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rw == id_rs);
    assign rt_match = id_use_rt & (ex_rw == id_rt);

    // $0 is hard-wired, so a load targeting it never produces a real dependency
    assign lu_hit = ex_valid & ex_memtoreg & (ex_rw != '0) & id_valid & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch/jump squash,
// global hold, and saturating stall/flush event counters.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int ACW   = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RW-1:0]     id_rs,
    input  logic [RW-1:0]     id_rt,
    input  logic [RW-1:0]     id_rw,
    input  logic              id_use_rt,
    input  logic [DW-1:0]     id_busA,
    input  logic [DW-1:0]     id_busB,
    input  logic [DW-1:0]     id_imm32,
    input  logic [DW-1:0]     id_pc4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [ACW-1:0]    id_aluctr,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [RW-1:0]     ex_rs,
    output logic [RW-1:0]     ex_rt,
    output logic [RW-1:0]     ex_rw,
    output logic [DW-1:0]     ex_busA,
    output logic [DW-1:0]     ex_busB,
    output logic [DW-1:0]     ex_imm32,
    output logic [DW-1:0]     ex_pc4,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [ACW-1:0]    ex_aluctr,
    output logic              pc_wr,
    output logic              ifid_wr,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [RW-1:0]     rs;
        logic [RW-1:0]     rt;
        logic [RW-1:0]     rw;
        logic [DW-1:0]     busA;
        logic [DW-1:0]     busB;
        logic [DW-1:0]     imm32;
        logic [DW-1:0]     pc4;
        logic [CTRL_W-1:0] ctrl;
        logic [ACW-1:0]    aluctr;
    } stage_t;

    stage_t    ex_q;
    stage_t    id_d;
    idex_act_e act;
    logic      lu_hit;

    assign id_d = '{valid: id_valid, rs: id_rs, rt: id_rt, rw: id_rw,
                    busA: id_busA, busB: id_busB, imm32: id_imm32, pc4: id_pc4,
                    ctrl: id_ctrl, aluctr: id_aluctr};

    load_use_detect #(.RW(RW)) u_lud (
        .ex_valid    (ex_q.valid),
        .ex_memtoreg (ex_q.ctrl[CTRL_MEMTOREG]),
        .ex_rw       (ex_q.rw),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rt   (id_use_rt),
        .lu_hit      (lu_hit)
    );

    // Flush outranks hold: a taken branch must squash even while memory stalls
    always_comb begin
        act        = ACT_NORMAL;
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        ifid_flush = 1'b0;
        if (flush) begin
            act        = ACT_FLUSH;
            ifid_flush = 1'b1;
        end else if (hold) begin
            act     = ACT_HOLD;
            pc_wr   = 1'b0;
            ifid_wr = 1'b0;
        end else if (lu_hit) begin
            act     = ACT_STALL;
            pc_wr   = 1'b0;
            ifid_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    ex_q <= '0;
                    if (~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
                end
                ACT_HOLD: begin
                    ex_q <= ex_q;
                end
                ACT_STALL: begin
                    ex_q <= '0;
                    if (~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
                end
                default: begin
                    ex_q <= id_d;
                end
            endcase
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_rs     = ex_q.rs;
    assign ex_rt     = ex_q.rt;
    assign ex_rw     = ex_q.rw;
    assign ex_busA   = ex_q.busA;
    assign ex_busB   = ex_q.busB;
    assign ex_imm32  = ex_q.imm32;
    assign ex_pc4    = ex_q.pc4;
    assign ex_ctrl   = ex_q.ctrl;
    assign ex_aluctr = ex_q.aluctr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed pipeline scenarios then random
// traffic, each cycle checked against a behavioural model of the stage.
module tb_id_ex_stage;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int ACW   = 4;
    localparam int CNT_W = 4;              // narrow counters so saturation is reachable
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [5:0]  ctrl;
        logic [3:0]  alu;
    } instr_t;

    typedef struct {
        logic [2:0] ctl;     // {pc_wr, ifid_wr, ifid_flush}
        instr_t     ex;
        int         stall;
        int         fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst, id_valid, id_use_rt, flush, hold;
    logic [RW-1:0] id_rs, id_rt, id_rw;
    logic [DW-1:0] id_busA, id_busB, id_imm32, id_pc4;
    logic [5:0] id_ctrl;
    logic [ACW-1:0] id_aluctr;
    logic ex_valid, pc_wr, ifid_wr, ifid_flush;
    logic [RW-1:0] ex_rs, ex_rt, ex_rw;
    logic [DW-1:0] ex_busA, ex_busB, ex_imm32, ex_pc4;
    logic [5:0] ex_ctrl;
    logic [ACW-1:0] ex_aluctr;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference state: what EX holds and how many events have been counted
    instr_t m_ex = '0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW), .ACW(ACW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rw(id_rw), .id_use_rt(id_use_rt), .id_busA(id_busA), .id_busB(id_busB),
        .id_imm32(id_imm32), .id_pc4(id_pc4), .id_ctrl(id_ctrl), .id_aluctr(id_aluctr),
        .flush(flush), .hold(hold), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rw(ex_rw), .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm32(ex_imm32),
        .ex_pc4(ex_pc4), .ex_ctrl(ex_ctrl), .ex_aluctr(ex_aluctr), .pc_wr(pc_wr),
        .ifid_wr(ifid_wr), .ifid_flush(ifid_flush), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic v, input int rs, input int rt, input int rw,
                                  input int a, input int b, input int imm, input logic [5:0] ctrl);
        instr_t i;
        i.valid = v;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rw = 5'(rw);
        i.a = 32'(a); i.b = 32'(b); i.imm = 32'(imm);
        i.pc4 = 32'h400 + 32'(rw * 4);
        i.ctrl = ctrl;
        i.alu = 4'(rw);
        return i;
    endfunction

    // One clock of stimulus; expected behaviour follows the stage's priority rules
    task automatic step(input instr_t id, input logic use_rt, input logic f, input logic h, input logic r);
        exp_t e;
        logic dep, lu;
        @(negedge clk); #1;
        rst = r; flush = f; hold = h;
        id_valid = id.valid; id_rs = id.rs; id_rt = id.rt; id_rw = id.rw;
        id_use_rt = use_rt; id_busA = id.a; id_busB = id.b; id_imm32 = id.imm;
        id_pc4 = id.pc4; id_ctrl = id.ctrl; id_aluctr = id.alu;

        dep = (m_ex.rw == id.rs) || (use_rt && m_ex.rw == id.rt);
        lu  = m_ex.valid && m_ex.ctrl[3] && (m_ex.rw != 0) && id.valid && dep;
        e.ctl = {f || !(h || lu), f || !(h || lu), f};

        if (r) begin
            m_ex = '0; m_stall = 0; m_flush = 0;
        end else if (f) begin
            m_ex = '0;
            m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end else if (h) begin
            // EX content and counters stay put
        end else if (lu) begin
            m_ex = '0;
            m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end else begin
            m_ex = id;
        end
        e.ex = m_ex; e.stall = m_stall; e.fl = m_flush;
        exp_q.push_back(e);
    endtask

    // Monitor: combinational controls mid-cycle, registered state just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ctl", 160'({pc_wr, ifid_wr, ifid_flush}), 160'(e.ctl));
                @(posedge clk); #1;
                chk("ex", 160'({ex_valid, ex_rs, ex_rt, ex_rw, ex_busA, ex_busB, ex_imm32,
                                ex_pc4, ex_ctrl, ex_aluctr}), 160'(e.ex));
                chk("stall_cnt", 160'(stall_cnt), 160'(e.stall));
                chk("flush_cnt", 160'(flush_cnt), 160'(e.fl));
            end
        end
    end

    initial begin
        instr_t nop, add1, lw8, dep9, addi9, lw0, r;
        nop   = '0;
        add1  = mk(1, 1, 2, 3, 5, 7, 0, 6'b100000);
        lw8   = mk(1, 1, 8, 8, 100, 0, 0, 6'b111000);
        dep9  = mk(1, 8, 2, 9, 11, 22, 0, 6'b100000);
        addi9 = mk(1, 0, 8, 9, 0, 33, 4, 6'b110000);
        lw0   = mk(1, 1, 0, 0, 100, 0, 0, 6'b111000);
        rst = 1; flush = 0; hold = 0; id_valid = 0; id_use_rt = 0;
        id_rs = 0; id_rt = 0; id_rw = 0; id_busA = 0; id_busB = 0;
        id_imm32 = 0; id_pc4 = 0; id_ctrl = 0; id_aluctr = 0;

        // Reset, then a plain add lands in EX one clock later
        step(nop, 0, 0, 0, 1);
        step(nop, 0, 0, 0, 1);
        step(add1, 1, 0, 0, 0);
        // Load-use: one bubble, then the dependent add proceeds
        step(lw8, 0, 0, 0, 0);
        step(dep9, 1, 0, 0, 0);
        step(dep9, 1, 0, 0, 0);
        // rt not read, and load into $0: neither stalls
        step(lw8, 0, 0, 0, 0);
        step(addi9, 0, 0, 0, 0);
        step(lw0, 0, 0, 0, 0);
        step(mk(1, 0, 0, 9, 1, 2, 3, 6'b100000), 1, 0, 0, 0);
        // Flush and load-use together: flush wins
        step(lw8, 0, 0, 0, 0);
        step(dep9, 1, 1, 0, 0);
        // Hold for three cycles with ID changing, then release
        step(add1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(mk(1, i + 4, i + 5, i + 6, i, i, i, 6'b100000), 1, 0, 1, 0);
        step(mk(1, 10, 11, 12, 13, 14, 15, 6'b100100), 1, 0, 0, 0);
        // Drive stall_cnt into saturation and beyond
        for (int i = 0; i < CMAX + 3; i++) begin
            step(lw8, 0, 0, 0, 0);
            step(dep9, 1, 0, 0, 0);
        end
        // Reset while a stall is pending
        step(lw8, 0, 0, 0, 0);
        step(dep9, 1, 0, 0, 1);
        step(dep9, 1, 0, 0, 0);

        // Random traffic over a small register pool so hazards are frequent
        for (int n = 0; n < 2500; n++) begin
            r.valid = ($urandom_range(0, 3) != 0);
            r.rs = 5'($urandom_range(0, 3));
            r.rt = 5'($urandom_range(0, 3));
            r.rw = 5'($urandom_range(0, 3));
            r.a = $urandom; r.b = $urandom; r.imm = $urandom; r.pc4 = $urandom;
            r.ctrl = 6'($urandom); r.alu = 4'($urandom);
            step(r, 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("drain", 160'(exp_q.size()), 160'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
